// File: rtl/sig_filter_bank.sv
// Multi-channel input conditioner: synchroniser, stable-count glitch filter and rise/fall strobes per channel.
// Optional sticky event flags with irq are present when SIG_FILTER_STICKY_EN is defined.
module sig_filter_bank #(
   parameter int   CHANNELS    = 4,
   parameter int   SYNC_STAGES = 2,
   parameter int   STABLE_CNT  = 8,
   parameter logic INIT_LEVEL  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] sig_in,
   output logic [CHANNELS-1:0] sig_out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                changed
`ifdef SIG_FILTER_STICKY_EN
   ,
   input  logic [CHANNELS-1:0] evt_clr,
   output logic [CHANNELS-1:0] evt_flag,
   output logic                irq
`endif
);

   localparam int CNT_W = $clog2(STABLE_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_reg [CHANNELS];
   logic [CNT_W-1:0]       cnt_reg  [CHANNELS];
   logic [CNT_W-1:0]       cnt_next [CHANNELS];

   logic [CHANNELS-1:0] sig_out_reg;
   logic [CHANNELS-1:0] rise_reg;
   logic [CHANNELS-1:0] fall_reg;
   logic                changed_reg;

   logic [CHANNELS-1:0] sync_last;
   logic [CHANNELS-1:0] differs;
   logic [CHANNELS-1:0] accept;

   // A channel accepts its new level on the edge where the count has already reached STABLE_CNT-1.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign sync_last[gi] = sync_reg[gi][SYNC_STAGES-1];
      assign differs[gi]   = sync_last[gi] ^ sig_out_reg[gi];
      assign accept[gi]    = differs[gi] && (cnt_reg[gi] == CNT_LAST);
      assign cnt_next[gi]  = (!differs[gi] || accept[gi]) ? '0 : cnt_reg[gi] + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            sync_reg[i] <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_reg[i]  <= '0;
         end
         sig_out_reg <= {CHANNELS{INIT_LEVEL}};
         rise_reg    <= '0;
         fall_reg    <= '0;
         changed_reg <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            sync_reg[i] <= {sync_reg[i][SYNC_STAGES-2:0], sig_in[i]};
            cnt_reg[i]  <= cnt_next[i];
         end
         sig_out_reg <= sig_out_reg ^ accept;
         rise_reg    <= accept & sync_last;
         fall_reg    <= accept & ~sync_last;
         changed_reg <= |accept;
      end
   end

   assign sig_out = sig_out_reg;
   assign rise    = rise_reg;
   assign fall    = fall_reg;
   assign changed = changed_reg;

`ifdef SIG_FILTER_STICKY_EN
   logic [CHANNELS-1:0] evt_flag_reg;
   logic [CHANNELS-1:0] evt_flag_next;
   logic                irq_reg;

   // Strobe set takes priority over a clear arriving on the same edge.
   assign evt_flag_next = (evt_flag_reg & ~evt_clr) | rise_reg | fall_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_flag_reg <= '0;
         irq_reg      <= 1'b0;
      end else begin
         evt_flag_reg <= evt_flag_next;
         irq_reg      <= |evt_flag_next;
      end
   end

   assign evt_flag = evt_flag_reg;
   assign irq      = irq_reg;
`endif

endmodule
